uart_imem_loader: RTL and testbench
===================================

# uart_imem_loader

Serial writer for the CPU's instruction memory. Receives 8N1 UART bytes from a host, packs them little-endian into 32-bit words, and issues single-cycle writes to the instruction memory write port while holding the CPU clock gate. It is the load-side counterpart to the CPU's ROM-address fetch path and sits in the top level beside the clock divider and display logic.

## Interface
- CLK_FREQ, 100_000_000: board clock frequency in Hz.
- BAUD, 115200: UART bit rate; DIV = CLK_FREQ/BAUD (integer, truncated), must be ≥ 4.
- ADDR_W, 6: instruction memory word-address width (64 words).

- clk  in  1  board clock; single clock domain.
- rstn  in  1  reset, asynchronous, active-low.
- uart_rx_i  in  1  serial input, idle high; asynchronous to clk.
- load_en_i  in  1  load session enable, from a switch; level.
- im_we_o  out  1  instruction memory write strobe, one cycle per word.
- im_addr_o  out  ADDR_W  word address of current write.
- im_wdata_o  out  32  word to write.
- cpu_hold_o  out  1  high while loading; top gates Clk_CPU with it.
- load_done_o  out  1  memory full; sticky until session ends.
- word_cnt_o  out  ADDR_W+1  words written this session.
- frame_err_o  out  1  sticky stop-bit error flag for this session.
- checksum_o  out  32  running sum of written words (see Configuration).

## Operation
- Input sync: uart_rx_i passes two flops before use; all rules below act on the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synced rx = 0 and session active, load counter DIV/2-1, go START.
  - START: at count 0 sample; 0 → DATA with bit index 0 and counter DIV-1; 1 → IDLE (glitch, no error).
  - DATA: each counter expiry samples one bit into shift register LSB-first; after bit 7 → STOP.
  - STOP: at expiry sample; 1 → byte valid for one cycle; 0 → frame_err_o set, byte discarded, byte index unchanged. Either way → IDLE.
- Packing: byte index 0..3; byte k goes to word bits [8k+7:8k]. On the 4th valid byte, drive im_wdata_o/im_addr_o and pulse im_we_o, increment address and word_cnt_o, reset byte index to 0.
- Full: when word_cnt_o reaches 2^ADDR_W, set load_done_o; further bytes are received but never written (no wrap-around).
- Session: rising edge of load_en_i clears address, word_cnt_o, byte index, frame_err_o, load_done_o, checksum_o. Session active while load_en_i = 1; cpu_hold_o = registered load_en_i.
- Falling edge of load_en_i mid-byte or mid-word: RX FSM aborts to IDLE, partial word discarded, counters and flags hold their values until next session start.
- Bytes while load_en_i = 0: ignored (FSM stays IDLE).

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0.
- im_we_o rises the cycle after the 4th byte's stop sample; high exactly one cycle; im_addr_o/im_wdata_o valid in that cycle and held until the next write.
- Start edge to stop sample: 2 (sync) + DIV/2 + 9·DIV cycles.
- Consecutive words are ≥ 40·DIV cycles apart; no backpressure, memory must accept every strobe.
- Simultaneous byte-valid and load_en_i falling edge: abort wins, no write.
- cpu_hold_o changes 1 cycle after load_en_i.

## Configuration
- UART_LOADER_CHECKSUM_EN defined: checksum_o accumulates im_wdata_o modulo 2^32 on every im_we_o, cleared at session start, for display on the seven-segment unit.
- Undefined: accumulator not built; checksum_o tied to 32'h0.

## Test plan
- CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10); session on, send 78 56 34 12 → one im_we_o pulse, addr 0, data 32'h12345678, word_cnt_o=1, checksum_o=32'h12345678 (0 without macro).
- Send 8 bytes 01 00 00 00 02 00 00 00 → writes addr 0 = 1, addr 1 = 2; checksum_o=3.
- Byte with stop bit 0 amid a word → frame_err_o=1, byte dropped, next 4 good bytes form word at addr 0.
- 3-cycle low glitch on uart_rx_i in IDLE → no byte, no error.
- Send 65 words → 64 writes, addrs 0..63, load_done_o=1, word_cnt_o=64, 65th word not written.
- Drop load_en_i after 2 bytes, re-raise, send 4 bytes → single write at addr 0 with the new bytes only; cpu_hold_o follows load_en_i by 1 cycle.

Source files
------------

// File: rtl/uart_imem_loader.sv
// UART (8N1) instruction-memory loader: packs received bytes little-endian into
// 32-bit words and writes them to the instruction memory while holding the CPU.
// Optional checksum accumulator is built when UART_LOADER_CHECKSUM_EN is defined.
module uart_imem_loader #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              uart_rx_i,
    input  logic              load_en_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              frame_err_o,
    output logic [31:0]       checksum_o
);

    localparam int unsigned DIV      = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W    = $clog2(DIV);
    localparam int unsigned FULL_CNT = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_meta;
    logic             rx_sync;
    logic [1:0]       byte_idx;
    logic [31:0]      word_buf;

    logic             en_rise_c;
    logic             stop_tick_c;
    logic             byte_ok_c;
    logic             byte_bad_c;
    logic             wr_c;
    logic [31:0]      wdata_c;

    // Two-flop synchronizer on the serial line; load_en_i is registered as the CPU hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            cpu_hold_o <= 1'b0;
        end else begin
            rx_meta    <= uart_rx_i;
            rx_sync    <= rx_meta;
            cpu_hold_o <= load_en_i;
        end
    end

    assign en_rise_c   = load_en_i & ~cpu_hold_o;
    assign stop_tick_c = (state == STOP) && (cnt == '0) && load_en_i;
    assign byte_ok_c   = stop_tick_c & rx_sync;
    assign byte_bad_c  = stop_tick_c & ~rx_sync;
    assign wr_c        = byte_ok_c && (byte_idx == 2'd3)
                         && (word_cnt_o != (ADDR_W+1)'(FULL_CNT));
    assign wdata_c     = {shift, word_buf[23:0]};

    // Receive FSM; dropping load_en_i aborts any frame in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (!load_en_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        cnt   <= CNT_W'(DIV / 2 - 1);
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_sync) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            cnt     <= CNT_W'(DIV - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift <= {rx_sync, shift[7:1]};
                        cnt   <= CNT_W'(DIV - 1);
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word packing, write strobe, session counters and flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx    <= '0;
            word_buf    <= '0;
            im_we_o     <= 1'b0;
            im_addr_o   <= '0;
            im_wdata_o  <= '0;
            word_cnt_o  <= '0;
            load_done_o <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            im_we_o <= 1'b0;
            if (en_rise_c) begin
                byte_idx    <= '0;
                im_addr_o   <= '0;
                word_cnt_o  <= '0;
                load_done_o <= 1'b0;
                frame_err_o <= 1'b0;
            end else if (!load_en_i) begin
                byte_idx <= '0;
            end else if (byte_bad_c) begin
                frame_err_o <= 1'b1;
            end else if (byte_ok_c) begin
                word_buf[{byte_idx, 3'b000} +: 8] <= shift;
                byte_idx <= byte_idx + 2'd1;
                if (wr_c) begin
                    im_we_o    <= 1'b1;
                    im_addr_o  <= word_cnt_o[ADDR_W-1:0];
                    im_wdata_o <= wdata_c;
                    word_cnt_o <= word_cnt_o + (ADDR_W+1)'(1);
                    if (word_cnt_o == (ADDR_W+1)'(FULL_CNT - 1)) begin
                        load_done_o <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    // Running sum of written words, updated with the write strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            checksum_o <= '0;
        end else if (en_rise_c) begin
            checksum_o <= '0;
        end else if (wr_c) begin
            checksum_o <= checksum_o + wdata_c;
        end
    end
`else
    assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: serial byte stimulus, a queue-based
// model of expected memory writes, and a per-cycle output compare process.
module tb_uart_imem_loader;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DIV      = CLK_FREQ / BAUD;
    localparam int unsigned NWORDS   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic              uart_rx;
    logic              load_en;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic [ADDR_W:0]   word_cnt;
    logic              frame_err;
    logic [31:0]       checksum;

    uart_imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .uart_rx_i(uart_rx), .load_en_i(load_en),
        .im_we_o(im_we), .im_addr_o(im_addr), .im_wdata_o(im_wdata),
        .cpu_hold_o(cpu_hold), .load_done_o(load_done), .word_cnt_o(word_cnt),
        .frame_err_o(frame_err), .checksum_o(checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: expected writes, partial bytes, session-level error
    wr_t        exp_q[$];
    logic [7:0] part_q[$];
    int         m_words = 0;
    logic       m_err   = 1'b0;

    // Values tracked by the compare process from observed strobes
    int          m_cnt = 0;
    logic [31:0] m_sum = '0;
    logic        en_d1 = 1'b0;
    logic        en_d2 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef UART_LOADER_CHECKSUM_EN
        return s;
`else
        return 32'h0 & s;
`endif
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic good);
        logic [31:0] w;
        if (!good) begin
            m_err = 1'b1;
        end else begin
            part_q.push_back(b);
            if (part_q.size() == 4) begin
                w = {part_q[3], part_q[2], part_q[1], part_q[0]};
                part_q.delete();
                if (m_words < int'(NWORDS)) begin
                    exp_q.push_back('{addr: ADDR_W'(m_words), data: w});
                    m_words++;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_en(input logic v);
        if (v && !load_en) begin
            part_q.delete();
            m_words = 0;
            m_err   = 1'b0;
        end else if (!v) begin
            part_q.delete();
        end
        load_en = v;
        tick(3);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        model_byte(b, stop);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop;
        tick(DIV);
        uart_rx = 1'b1;
        tick(2 * DIV);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        wr_t e;
        if (rstn) begin
            if (en_d1 && !en_d2) begin
                m_cnt = 0;
                m_sum = '0;
            end
            chk("cpu_hold", 32'(cpu_hold), 32'(en_d1));
            if (im_we) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 32'(im_we), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(im_addr), 32'(e.addr));
                    chk("wr_data", im_wdata, e.data);
                    m_cnt++;
                    m_sum = m_sum + e.data;
                end
            end
            chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
            chk("load_done", 32'(load_done), 32'(m_cnt == int'(NWORDS)));
            chk("checksum", checksum, exp_sum(m_sum));
            en_d2 = en_d1;
            en_d1 = load_en;
        end
    end

    initial begin
        logic [31:0] w;
        rstn    = 1'b0;
        uart_rx = 1'b1;
        load_en = 1'b0;
        tick(3);
        chk("rst_we", 32'(im_we), 32'h0);
        chk("rst_addr", 32'(im_addr), 32'h0);
        chk("rst_wdata", im_wdata, 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        chk("rst_done", 32'(load_done), 32'h0);
        chk("rst_cnt", 32'(word_cnt), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_csum", checksum, 32'h0);
        rstn = 1'b1;
        tick(2);

        // Single word
        set_en(1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        chk("t1_data", im_wdata, 32'h12345678);
        chk("t1_addr", 32'(im_addr), 32'h0);
        chk("t1_cnt", 32'(word_cnt), 32'h1);
        chk("t1_csum", checksum, exp_sum(32'h12345678));

        // Two words in a fresh session
        set_en(1'b0);
        set_en(1'b1);
        send_word(32'h1);
        send_word(32'h2);
        chk("t2_data", im_wdata, 32'h2);
        chk("t2_addr", 32'(im_addr), 32'h1);
        chk("t2_cnt", 32'(word_cnt), 32'h2);
        chk("t2_csum", checksum, exp_sum(32'h3));

        // Framing error mid-word: bad byte dropped
        set_en(1'b0);
        set_en(1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'hFF, 1'b0);
        chk("t3_ferr_set", 32'(frame_err), 32'(m_err));
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("t3_data", im_wdata, 32'h44332211);
        chk("t3_addr", 32'(im_addr), 32'h0);
        chk("t3_ferr", 32'(frame_err), 32'h1);

        // Short low glitch while idle
        set_en(1'b0);
        set_en(1'b1);
        chk("t4_ferr_clr", 32'(frame_err), 32'h0);
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(4 * DIV);
        chk("t4_ferr", 32'(frame_err), 32'(m_err));
        chk("t4_cnt", 32'(word_cnt), 32'h0);

        // Fill memory and overflow by one word
        set_en(1'b0);
        set_en(1'b1);
        for (int i = 0; i <= int'(NWORDS); i++) begin
            w = 32'hA500_0000 | 32'(i);
            send_word(w);
        end
        chk("t5_cnt", 32'(word_cnt), 32'(NWORDS));
        chk("t5_done", 32'(load_done), 32'h1);
        chk("t5_addr", 32'(im_addr), 32'(NWORDS - 1));
        chk("t5_data", im_wdata, 32'hA500_003F);
        chk("t5_csum", checksum, exp_sum(32'h4000_07E0));
        set_en(1'b0);
        chk("t5_hold_cnt", 32'(word_cnt), 32'(NWORDS));
        chk("t5_hold_done", 32'(load_done), 32'h1);

        // Abort after two bytes, then a clean word
        set_en(1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hFF, 1'b1);
        set_en(1'b0);
        set_en(1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        chk("t6_data", im_wdata, 32'h04030201);
        chk("t6_addr", 32'(im_addr), 32'h0);
        chk("t6_cnt", 32'(word_cnt), 32'h1);
        chk("t6_done", 32'(load_done), 32'h0);

        tick(5);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
